// File: rtl/shift_ring_pkg.sv
// Shared encodings for the shift-register ring/Johnson counter.
package shift_ring_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD       = 2'b00,
        MODE_RING_SC    = 2'b01,
        MODE_JOHNSON    = 2'b10,
        MODE_JOHNSON_SC = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_TO_MSB = 1'b0,
        DIR_TO_LSB = 1'b1
    } dir_e;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider; tick is high for one exCLK cycle out of every DIV.
module tick_prescaler #(
    parameter int DIV = 27000000
) (
    input  logic exCLK,
    input  logic RST,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge exCLK or posedge RST) begin
        if (RST)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // With DIV=1 cnt never leaves 0, so tick stays high.
    assign tick = (cnt == LAST);

endmodule

// File: rtl/shift_ring_counter.sv
// WIDTH-bit ring / Johnson shift counter with prescaled stepping, parallel
// load, self-correction, wrap pulse and illegal-state decode.
module shift_ring_counter
    import shift_ring_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIV   = 27000000
) (
    input  logic             exCLK,
    input  logic             RST,
    input  logic             CLKen,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] Q,
    output logic             tick,
    output logic             wrap,
    output logic             illegal
);
    mode_e            m;
    logic             step;
    logic             exit_bit;
    logic [WIDTH-2:0] kept;
    logic             sin;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] start;
    int               trans;

    assign m = mode_e'(mode);

    tick_prescaler #(.DIV(DIV)) u_prescaler (
        .exCLK (exCLK),
        .RST   (RST),
        .tick  (tick)
    );

    assign step = tick & CLKen & (m != MODE_HOLD) & ~load;

    always_comb begin
        trans = 0;
        for (int i = 0; i < WIDTH - 1; i++)
            if (Q[i] != Q[i+1]) trans = trans + 1;
        case (m)
            MODE_RING_SC:                 illegal = ($countones(Q) != 1);
            MODE_JOHNSON, MODE_JOHNSON_SC: illegal = (trans > 1);
            default:                      illegal = 1'b0;
        endcase
    end

    always_comb begin
        exit_bit = (dir == DIR_TO_LSB) ? Q[0] : Q[WIDTH-1];
        kept     = (dir == DIR_TO_LSB) ? Q[WIDTH-1:1] : Q[WIDTH-2:0];
        sin      = 1'b0;
        start    = '0;
        case (m)
            MODE_RING_SC: begin
                // Inject a 1 only when the surviving bits are empty: extra
                // ones shift out and never get replaced.
                sin   = ~|kept;
                start = (dir == DIR_TO_LSB) ? {1'b1, {(WIDTH-1){1'b0}}}
                                            : {{(WIDTH-1){1'b0}}, 1'b1};
            end
            MODE_JOHNSON, MODE_JOHNSON_SC: sin = ~exit_bit;
            default: ;
        endcase
        shifted = (dir == DIR_TO_LSB) ? {sin, kept} : {kept, sin};
        q_next  = (m == MODE_JOHNSON_SC && illegal) ? '0 : shifted;
    end

    always_ff @(posedge exCLK or posedge RST) begin
        if (RST) begin
            Q    <= '0;
            wrap <= 1'b0;
        end else if (load) begin
            Q    <= load_val;
            wrap <= 1'b0;
        end else if (step) begin
            Q    <= q_next;
            wrap <= (q_next == start);
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_ring_counter.sv
// Scenario bench for shift_ring_counter at WIDTH=4, DIV=4.
module tb_shift_ring_counter;
    logic       exCLK = 1'b0;
    logic       RST = 1'b1;
    logic       CLKen = 1'b0;
    logic [1:0] mode = 2'b01;
    logic       dir = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'b0000;
    logic [3:0] Q;
    logic       tick, wrap, illegal;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] q;
        logic       w;
        logic       ill;
    } exp_t;
    exp_t sb[$];

    shift_ring_counter #(.WIDTH(4), .DIV(4)) dut (
        .exCLK(exCLK), .RST(RST), .CLKen(CLKen), .mode(mode), .dir(dir),
        .load(load), .load_val(load_val), .Q(Q), .tick(tick), .wrap(wrap),
        .illegal(illegal)
    );

    always #5 exCLK = ~exCLK;

    // Waits for a tick and returns #1 after the edge that consumes it.
    task automatic wait_step(output bit ok, output int n);
        ok = 0;
        n  = 0;
        while (!ok && n < 16) begin
            @(negedge exCLK);
            n++;
            if (tick) begin
                @(posedge exCLK);
                #1;
                ok = 1;
            end
        end
    endtask

    task automatic do_load(input logic [3:0] v);
        load = 1'b1;
        load_val = v;
        @(posedge exCLK);
        #1;
        load = 1'b0;
    endtask

    task automatic push(input logic [3:0] q, input logic w, input logic ill);
        exp_t e;
        e.q = q; e.w = w; e.ill = ill;
        sb.push_back(e);
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if (Q !== 4'b0000 || wrap !== 1'b0 || tick !== 1'b0 || illegal !== 1'b1) begin
            errors++;
            $display("FAIL reset: Q=%b wrap=%b tick=%b illegal=%b expected 0000 0 0 1",
                     Q, wrap, tick, illegal);
        end
        @(negedge exCLK);
        RST = 1'b0;
        CLKen = 1'b1;
    endtask

    task automatic test_ring;
        bit ok; int n; exp_t e; int i;
        push(4'b0001, 1, 0); push(4'b0010, 0, 0); push(4'b0100, 0, 0);
        push(4'b1000, 0, 0); push(4'b0001, 1, 0);
        i = 0;
        while (sb.size() > 0) begin
            wait_step(ok, n);
            e = sb.pop_front();
            checks++;
            if (!ok || Q !== e.q || wrap !== e.w || illegal !== e.ill) begin
                errors++;
                $display("FAIL ring step%0d: ok=%0d Q=%b wrap=%b ill=%b expected Q=%b wrap=%b ill=%b",
                         i, ok, Q, wrap, illegal, e.q, e.w, e.ill);
            end
            if (i > 0) begin
                checks++;
                if (n != 4) begin
                    errors++;
                    $display("FAIL tick_period: %0d cycles expected 4", n);
                end
            end
            i++;
        end
        @(posedge exCLK);
        #1;
        checks++;
        if (wrap !== 1'b0) begin
            errors++;
            $display("FAIL wrap_one_cycle: wrap=%b expected 0", wrap);
        end
    endtask

    task automatic test_johnson;
        bit ok; int n; exp_t e;
        mode = 2'b10;
        do_load(4'b0000);
        checks++;
        if (Q !== 4'b0000 || wrap !== 1'b0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL johnson_load: Q=%b wrap=%b ill=%b expected 0000 0 0", Q, wrap, illegal);
        end
        push(4'b0001, 0, 0); push(4'b0011, 0, 0); push(4'b0111, 0, 0); push(4'b1111, 0, 0);
        push(4'b1110, 0, 0); push(4'b1100, 0, 0); push(4'b1000, 0, 0); push(4'b0000, 1, 0);
        while (sb.size() > 0) begin
            wait_step(ok, n);
            e = sb.pop_front();
            checks++;
            if (!ok || Q !== e.q || wrap !== e.w || illegal !== e.ill) begin
                errors++;
                $display("FAIL johnson step: ok=%0d Q=%b wrap=%b ill=%b expected Q=%b wrap=%b ill=%b",
                         ok, Q, wrap, illegal, e.q, e.w, e.ill);
            end
        end
    endtask

    task automatic test_correction;
        bit ok; int n; exp_t e;
        mode = 2'b01;
        do_load(4'b0110);
        checks++;
        if (illegal !== 1'b1 || Q !== 4'b0110) begin
            errors++;
            $display("FAIL ring_illegal: Q=%b ill=%b expected 0110 1", Q, illegal);
        end
        push(4'b1100, 0, 1); push(4'b1000, 0, 0); push(4'b0001, 1, 0);
        while (sb.size() > 0) begin
            wait_step(ok, n);
            e = sb.pop_front();
            checks++;
            if (!ok || Q !== e.q || wrap !== e.w || illegal !== e.ill) begin
                errors++;
                $display("FAIL ring_recover: ok=%0d Q=%b wrap=%b ill=%b expected Q=%b wrap=%b ill=%b",
                         ok, Q, wrap, illegal, e.q, e.w, e.ill);
            end
        end
        mode = 2'b11;
        do_load(4'b0101);
        checks++;
        if (illegal !== 1'b1) begin
            errors++;
            $display("FAIL johnson_illegal: ill=%b expected 1", illegal);
        end
        push(4'b0000, 1, 0); push(4'b0001, 0, 0);
        while (sb.size() > 0) begin
            wait_step(ok, n);
            e = sb.pop_front();
            checks++;
            if (!ok || Q !== e.q || wrap !== e.w || illegal !== e.ill) begin
                errors++;
                $display("FAIL johnson_recover: ok=%0d Q=%b wrap=%b ill=%b expected Q=%b wrap=%b ill=%b",
                         ok, Q, wrap, illegal, e.q, e.w, e.ill);
            end
        end
    endtask

    task automatic test_dir_and_enable;
        bit ok; int n; exp_t e; int ticks;
        mode = 2'b01;
        dir = 1'b1;
        do_load(4'b0000);
        push(4'b1000, 1, 0); push(4'b0100, 0, 0); push(4'b0010, 0, 0);
        push(4'b0001, 0, 0); push(4'b1000, 1, 0);
        while (sb.size() > 0) begin
            wait_step(ok, n);
            e = sb.pop_front();
            checks++;
            if (!ok || Q !== e.q || wrap !== e.w || illegal !== e.ill) begin
                errors++;
                $display("FAIL dir1 step: ok=%0d Q=%b wrap=%b ill=%b expected Q=%b wrap=%b ill=%b",
                         ok, Q, wrap, illegal, e.q, e.w, e.ill);
            end
        end
        CLKen = 1'b0;
        ticks = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge exCLK);
            if (tick) ticks++;
        end
        checks++;
        if (Q !== 4'b1000 || ticks != 2) begin
            errors++;
            $display("FAIL clken_hold: Q=%b ticks=%0d expected 1000 2", Q, ticks);
        end
        @(posedge exCLK);
        #1;
        do_load(4'b1010);
        checks++;
        if (Q !== 4'b1010 || illegal !== 1'b1) begin
            errors++;
            $display("FAIL load_while_disabled: Q=%b ill=%b expected 1010 1", Q, illegal);
        end
    endtask

    task automatic test_load_vs_step;
        bit ok; int n; int guard;
        dir = 1'b0;
        CLKen = 1'b1;
        guard = 0;
        do begin
            @(negedge exCLK);
            guard++;
        end while (!tick && guard < 16);
        load = 1'b1;
        load_val = 4'b0010;
        @(posedge exCLK);
        #1;
        load = 1'b0;
        checks++;
        if (Q !== 4'b0010 || wrap !== 1'b0 || guard >= 16) begin
            errors++;
            $display("FAIL load_wins: Q=%b wrap=%b expected 0010 0", Q, wrap);
        end
        wait_step(ok, n);
        checks++;
        if (!ok || Q !== 4'b0100 || n != 4) begin
            errors++;
            $display("FAIL phase_kept: Q=%b cycles=%0d expected 0100 4", Q, n);
        end
    endtask

    task automatic test_async_reset;
        int n;
        #3;
        RST = 1'b1;
        #1;
        checks++;
        if (Q !== 4'b0000 || wrap !== 1'b0 || tick !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: Q=%b wrap=%b tick=%b expected 0000 0 0", Q, wrap, tick);
        end
        @(negedge exCLK);
        RST = 1'b0;
        n = 0;
        do begin
            @(posedge exCLK);
            #1;
            n++;
        end while (Q === 4'b0000 && n < 12);
        checks++;
        if (n != 4 || Q !== 4'b0001 || wrap !== 1'b1) begin
            errors++;
            $display("FAIL first_step_after_reset: edges=%0d Q=%b wrap=%b expected 4 0001 1",
                     n, Q, wrap);
        end
    endtask

    initial begin
        test_reset();
        test_ring();
        test_johnson();
        test_correction();
        test_dir_and_enable();
        test_load_vs_step();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_ring_counter.md
# shift_ring_counter

Parametrised shift-register counter with an on-chip prescaler. It generalises the 4-bit 74LS194-style twisted/ring counter to WIDTH bits. It adds selectable ring / Johnson / self-correcting modes, shift direction, synchronous parallel load, and illegal-state and wrap flags. The block runs from the board clock exCLK. Stepping is qualified by a prescaler tick and the CLKen enable; the block never gates a clock, so it drives LED/display stages directly.

## Interface
- WIDTH, 4: counter length in bits; must be ≥ 2.
- DIV, 27000000: prescaler period in exCLK cycles; must be ≥ 1.
- exCLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- CLKen  in  1  step enable; sampled on the same edge as tick.
- mode  in  2  operating mode: 00 hold, 01 self-correcting ring, 10 Johnson, 11 self-correcting Johnson.
- dir  in  1  shift direction: 0 shifts toward MSB (new bit enters Q[0]), 1 shifts toward LSB (new bit enters Q[WIDTH-1]).
- load  in  1  synchronous parallel load strobe.
- load_val  in  WIDTH  value loaded when load=1.
- Q  out  WIDTH  counter state.
- tick  out  1  prescaler terminal count: high while the internal count equals DIV-1.
- wrap  out  1  one-cycle pulse: a step has just produced the start pattern.
- illegal  out  1  current Q is not a valid state for the current mode.

## Operation
- Prescaler: cnt counts 0..DIV-1 and wraps; it is free-running and independent of CLKen, mode and load. tick = (cnt == DIV-1), decoded combinationally. With DIV=1, tick is constantly high.
- Step condition: tick & CLKen & mode≠00 & !load.
- Priority per edge: RST > load > step > hold.
- load: Q ← load_val on any edge with load=1, independent of tick. load never raises wrap.
- Serial-in bit sin and shift:
  - dir=0: Q ← {Q[WIDTH-2:0], sin}.
  - dir=1: Q ← {sin, Q[WIDTH-1:1]}.
- sin by mode:
  - Mode 01: sin = 1 if the WIDTH-1 bits being kept, excluding the exiting bit, are all 0; else 0. Any state reaches the one-hot cycle within WIDTH-1 steps.
  - Mode 10: sin = inverted exiting bit (~Q[WIDTH-1] for dir=0, ~Q[0] for dir=1). Period is 2·WIDTH. There is no correction.
  - Mode 11: same as mode 10. If illegal=1 at the step, Q ← 0 instead of shifting.
- Start pattern:
  - Modes 01: one-hot at the entry end (Q[0] for dir=0, Q[WIDTH-1] for dir=1).
  - Modes 10/11: all zeros.
- wrap: registered. It is high for exactly the one cycle after a step whose new Q equals the start pattern.
- illegal: combinational.
  - Mode 00: 0.
  - Modes 01: popcount(Q) ≠ 1.
  - Modes 10/11: more than one i in 0..WIDTH-2 with Q[i] ≠ Q[i+1].
- mode or dir changes take effect at the next step. Q is not reset on a change; self-correcting modes recover on their own.

## Timing
- Reset values: Q=0, cnt=0, wrap=0. Consequently tick=0 (1 if DIV=1), and illegal=1 in mode 01, 0 otherwise.
- Latency: Q and wrap update one edge after the step or load condition. illegal follows Q combinationally in the same cycle.
- Step rate: one step per DIV cycles while CLKen=1. CLKen=0 freezes Q; the prescaler keeps counting.
- RST asserted mid-run clears all state immediately, without waiting for an edge. The first tick after release comes DIV cycles after the first clock edge.
- load coinciding with a step: load wins and that step is lost. The prescaler phase is unaffected.
- load coinciding with the exit from reset: RST dominates.

## Structure
- Package shift_ring_pkg holds the mode encodings (MODE_HOLD, MODE_RING_SC, MODE_JOHNSON, MODE_JOHNSON_SC) and the dir encodings.
- Sub-module tick_prescaler (parameter DIV; ports exCLK, RST, tick) holds the divider. The top level holds the shift register, the sin/illegal decode and the wrap register.

## Test plan
All scenarios use WIDTH=4, DIV=4.
- Reset, then mode 01, dir 0, CLKen 1 → tick every 4th cycle; Q sequence 0000, 0001, 0010, 0100, 1000, 0001; wrap pulses after each step that produces 0001; illegal is 1 only at 0000.
- Mode 10, dir 0, from 0000 → Q sequence 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000; wrap pulses once per 8 steps.
- load 0110 in mode 01 → illegal=1; steps give 1100, 1000, 0001. load 0101 in mode 11 → illegal=1; the next step gives 0000, then 0001.
- mode 01, dir 1 from 0000 → 1000, 0100, 0010, 0001, 1000. Toggling CLKen to 0 holds Q while tick continues. load 1010 applied while CLKen=0 still loads.
- RST asserted between clock edges mid-sequence → Q=0 and wrap=0 with no clock edge. After release, the first step occurs on the first tick, DIV edges later.
